multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP FSM,
// combinational strobe decode from state and instr, retired-instruction counter.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        memread,
  output logic        memwrite,
  output logic        iord,
  output logic        irwrite,
  output logic        pcinc,
  output logic        dobranch,
  output logic        dojump,
  output logic        alusrcbimm,
  output logic        memtoreg,
  output logic        regwrite,
  output logic [4:0]  destreg,
  output logic [2:0]  alucontrol,
  output logic        illegal,
  output logic [15:0] instret
);

  localparam int unsigned RetW = 16;
  localparam int unsigned OpW  = 6;
  localparam int unsigned AluW = 3;

  localparam logic [OpW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OpW-1:0] OP_LW    = 6'b100011;
  localparam logic [OpW-1:0] OP_SW    = 6'b101011;
  localparam logic [OpW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OpW-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OpW-1:0] OP_J     = 6'b000010;
  localparam logic [OpW-1:0] OP_LUI   = 6'b001111;
  localparam logic [OpW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OpW-1:0] OP_BLTZ  = 6'b000001;

  localparam logic [AluW-1:0] ALU_AND = 3'b000;
  localparam logic [AluW-1:0] ALU_OR  = 3'b001;
  localparam logic [AluW-1:0] ALU_ADD = 3'b010;
  localparam logic [AluW-1:0] ALU_UND = 3'b011;
  localparam logic [AluW-1:0] ALU_SUB = 3'b110;
  localparam logic [AluW-1:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [RetW-1:0] instret_q, instret_d;

  logic [OpW-1:0]  opcode;
  logic [OpW-1:0]  funct;
  logic            known_op_c;
  logic [AluW-1:0] alu_ctl_c;
  logic            alu_imm_c;
  logic            is_rtype_c;
  logic            is_lw_c;
  logic            retire_c;
  logic            unused_instr_c;

  assign opcode         = instr[31:26];
  assign funct          = instr[5:0];
  assign is_rtype_c     = (opcode == OP_RTYPE);
  assign is_lw_c        = (opcode == OP_LW);
  assign unused_instr_c = ^{instr[25:21], instr[10:6]};

  // Opcode/funct decode into ALU controls and legality.
  always_comb begin
    known_op_c = 1'b1;
    alu_ctl_c  = ALU_ADD;
    alu_imm_c  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          6'b100001: alu_ctl_c = ALU_ADD;
          6'b100011: alu_ctl_c = ALU_SUB;
          6'b100100: alu_ctl_c = ALU_AND;
          6'b100101: alu_ctl_c = ALU_OR;
          6'b101011: alu_ctl_c = ALU_SLT;
          default:   alu_ctl_c = ALU_UND;
        endcase
      end
      OP_LW, OP_SW, OP_ADDIU, OP_LUI: begin
        alu_ctl_c = ALU_ADD;
        alu_imm_c = 1'b1;
      end
      OP_ORI: begin
        alu_ctl_c = ALU_OR;
        alu_imm_c = 1'b1;
      end
      OP_BEQ:  alu_ctl_c = ALU_SUB;
      OP_BLTZ: alu_ctl_c = ALU_SLT;
      OP_J:    alu_ctl_c = ALU_ADD;
      default: known_op_c = 1'b0;
    endcase
  end

  // Next-state and output decode; reset low forces every strobe off at once.
  always_comb begin
    state_d    = state_q;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcinc      = 1'b0;
    dobranch   = 1'b0;
    dojump     = 1'b0;
    alusrcbimm = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    destreg    = 5'd0;
    alucontrol = ALU_AND;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcinc   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = known_op_c ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alucontrol = alu_ctl_c;
        alusrcbimm = alu_imm_c;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ: begin
            dobranch = zero;
            state_d  = S_FETCH;
          end
          OP_BLTZ: begin
            dobranch = ~zero;
            state_d  = S_FETCH;
          end
          OP_J: begin
            dojump  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        iord       = 1'b1;
        alucontrol = ALU_ADD;
        alusrcbimm = 1'b1;
        memread    = is_lw_c;
        memwrite   = ~is_lw_c;
        if (mem_ready) state_d = is_lw_c ? S_WB : S_FETCH;
      end
      S_WB: begin
        regwrite   = 1'b1;
        destreg    = is_rtype_c ? instr[15:11] : instr[20:16];
        memtoreg   = is_lw_c;
        alucontrol = alu_ctl_c;
        alusrcbimm = alu_imm_c;
        state_d    = S_FETCH;
      end
      S_TRAP:  illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
    if (!reset) begin
      state_d    = S_FETCH;
      memread    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcinc      = 1'b0;
      dobranch   = 1'b0;
      dojump     = 1'b0;
      alusrcbimm = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      destreg    = 5'd0;
      alucontrol = ALU_AND;
      illegal    = 1'b0;
    end
  end

  // Count retirements: any return to FETCH from EXEC, MEM or WB.
  always_comb begin
    retire_c  = (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) &&
                (state_d == S_FETCH);
    instret_d = retire_c ? instret_q + RetW'(1) : instret_q;
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule
